// File: rtl/lb_hub.sv
`timescale 1ns/1ps
// lb_hub: registered local-bus hub that decodes slave windows plus a local register window,
// tracks one outstanding slave read with timeout, and collects bus errors in a W1C status register.
module lb_hub #(
  parameter int          NUM_SLV   = 2,
  parameter int          WIN_BITS  = 4,
  parameter int          ADDR_BITS = 8,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] HUB_ID    = 32'h11223344
) (
  input  logic                    clk_lb,
  input  logic                    reset,
  input  logic                    lb_wr,
  input  logic                    lb_rd,
  input  logic [31:0]             lb_addr,
  input  logic [31:0]             lb_wr_d,
  output logic [31:0]             lb_rd_d,
  output logic                    lb_rd_rdy,
  input  logic [31:0]             time_stamp_d,
  output logic [NUM_SLV-1:0]      slv_cs,
  output logic                    slv_wr,
  output logic                    slv_rd,
  output logic [WIN_BITS-1:0]     slv_addr,
  output logic [31:0]             slv_wr_d,
  input  logic [NUM_SLV*32-1:0]   slv_rd_d,
  input  logic [NUM_SLV-1:0]      slv_rd_rdy,
  output logic                    err_irq
);

  localparam logic [31:0] BAD_DATA = 32'hDEADBEEF;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t              state, state_nxt;
  logic [15:0]         cnt, cnt_nxt;
  logic [31:0]         win;
  logic                loc_hit, slv_hit, unm_hit;
  logic                rd_accept, slv_rd_go, wr_go, overrun;
  logic [NUM_SLV-1:0]  cs_dec;
  logic [31:0]         sel_d;
  logic                rdy_any, rdy_multi;
  logic                fsm_rsp, set_to, set_multi;
  logic [31:0]         fsm_rsp_d;

  logic                p1_loc_rd, p1_unm_rd, p1_loc_wr, p1_unm_wr;
  logic [WIN_BITS-1:0] p1_off;
  logic [3:0]          p1_clr_bits;
  logic                p1_clr_cnt;

  logic [3:0]          flags;
  logic [7:0]          err_cnt;
  logic [31:0]         status_word;
  logic [31:0]         loc_d;
  logic                rsp_vld;
  logic [31:0]         rsp_d;
  logic [3:0]          set_vec, clr_vec;
  logic                cnt_clr;
  logic                unused_addr;

  assign unused_addr = &{1'b0, lb_addr[31:ADDR_BITS]};

  assign win     = 32'(lb_addr[ADDR_BITS-1:WIN_BITS]);
  assign loc_hit = (win == 32'd0);
  assign slv_hit = (win != 32'd0) && (win <= 32'(NUM_SLV));
  assign unm_hit = !loc_hit && !slv_hit;

  // While a slave read is outstanding every new master read is swallowed as an overrun.
  assign rd_accept = lb_rd && (state == ST_IDLE);
  assign overrun   = lb_rd && (state == ST_WAIT);
  assign slv_rd_go = rd_accept && slv_hit;
  assign wr_go     = lb_wr && slv_hit;

  always_comb begin
    cs_dec = '0;
    for (int i = 0; i < NUM_SLV; i++) cs_dec[i] = (win == 32'(i + 1));
  end

  // Lowest responding slave index wins when several raise rdy together.
  always_comb begin
    sel_d = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (slv_rd_rdy[i]) sel_d = slv_rd_d[32*i +: 32];
    end
  end

  assign rdy_any   = |slv_rd_rdy;
  assign rdy_multi = (slv_rd_rdy & (slv_rd_rdy - NUM_SLV'(1))) != '0;

  always_ff @(posedge clk_lb or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fsm_rsp   = 1'b0;
    fsm_rsp_d = '0;
    set_to    = 1'b0;
    set_multi = 1'b0;
    case (state)
      ST_IDLE: begin
        set_multi = rdy_any;
        if (slv_rd_go) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = 16'(TIMEOUT);
        end
      end
      ST_WAIT: begin
        if (rdy_any) begin
          fsm_rsp   = 1'b1;
          fsm_rsp_d = sel_d;
          set_multi = rdy_multi;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == 16'd0) begin
          fsm_rsp   = 1'b1;
          fsm_rsp_d = BAD_DATA;
          set_to    = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_lb or negedge reset) begin
    if (!reset) begin
      slv_cs      <= '0;
      slv_wr      <= 1'b0;
      slv_rd      <= 1'b0;
      slv_addr    <= '0;
      slv_wr_d    <= '0;
      p1_loc_rd   <= 1'b0;
      p1_unm_rd   <= 1'b0;
      p1_loc_wr   <= 1'b0;
      p1_unm_wr   <= 1'b0;
      p1_off      <= '0;
      p1_clr_bits <= '0;
      p1_clr_cnt  <= 1'b0;
    end else begin
      slv_cs      <= (wr_go || slv_rd_go) ? cs_dec : '0;
      slv_wr      <= wr_go;
      slv_rd      <= slv_rd_go;
      slv_addr    <= lb_addr[WIN_BITS-1:0];
      slv_wr_d    <= lb_wr_d;
      p1_loc_rd   <= rd_accept && loc_hit;
      p1_unm_rd   <= rd_accept && unm_hit;
      p1_loc_wr   <= lb_wr && loc_hit;
      p1_unm_wr   <= lb_wr && unm_hit;
      p1_off      <= lb_addr[WIN_BITS-1:0];
      p1_clr_bits <= lb_wr_d[3:0];
      p1_clr_cnt  <= lb_wr_d[31];
    end
  end

  assign status_word = {16'd0, err_cnt, 4'd0, flags};
  assign err_irq     = |flags;

  always_comb begin
    loc_d = '0;
    case (32'(p1_off))
      32'h0:   loc_d = HUB_ID;
      32'h4:   loc_d = {16'd0, 8'(NUM_SLV), 8'(WIN_BITS)};
      32'h8:   loc_d = time_stamp_d;
      32'hC:   loc_d = status_word;
      default: loc_d = '0;
    endcase
  end

  always_comb begin
    rsp_vld = fsm_rsp || p1_loc_rd || p1_unm_rd;
    rsp_d   = '0;
    if (fsm_rsp)        rsp_d = fsm_rsp_d;
    else if (p1_unm_rd) rsp_d = BAD_DATA;
    else if (p1_loc_rd) rsp_d = loc_d;
  end

  always_ff @(posedge clk_lb or negedge reset) begin
    if (!reset) begin
      lb_rd_rdy <= 1'b0;
      lb_rd_d   <= '0;
    end else begin
      lb_rd_rdy <= rsp_vld;
      lb_rd_d   <= rsp_d;
    end
  end

  // Set beats clear on the same bit; the count bumps once per cycle with any set event.
  assign set_vec = {p1_unm_rd || p1_unm_wr, set_multi, overrun, set_to};
  assign clr_vec = (p1_loc_wr && (32'(p1_off) == 32'hC)) ? p1_clr_bits : 4'd0;
  assign cnt_clr = p1_loc_wr && (32'(p1_off) == 32'hC) && p1_clr_cnt;

  always_ff @(posedge clk_lb or negedge reset) begin
    if (!reset) begin
      flags   <= '0;
      err_cnt <= '0;
    end else begin
      flags <= (flags & ~clr_vec) | set_vec;
      if (cnt_clr)
        err_cnt <= (|set_vec) ? 8'd1 : 8'd0;
      else if ((|set_vec) && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_lb_hub.sv
`timescale 1ns/1ps
// tb_lb_hub: scoreboard bench for lb_hub; expected read responses are queued with their
// expected arrival cycle when the read is issued and matched when lb_rd_rdy pulses.
module tb_lb_hub;

  logic        clk_lb;
  logic        reset;
  logic        lb_wr, lb_rd;
  logic [31:0] lb_addr, lb_wr_d;
  logic [31:0] lb_rd_d;
  logic        lb_rd_rdy;
  logic [31:0] time_stamp_d;
  logic [1:0]  slv_cs;
  logic        slv_wr, slv_rd;
  logic [3:0]  slv_addr;
  logic [31:0] slv_wr_d;
  logic [63:0] slv_rd_d;
  logic [1:0]  slv_rd_rdy;
  logic        err_irq;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  lb_hub #(
    .NUM_SLV(2), .WIN_BITS(4), .ADDR_BITS(8), .TIMEOUT(8), .HUB_ID(32'h11223344)
  ) dut (
    .clk_lb(clk_lb), .reset(reset),
    .lb_wr(lb_wr), .lb_rd(lb_rd), .lb_addr(lb_addr), .lb_wr_d(lb_wr_d),
    .lb_rd_d(lb_rd_d), .lb_rd_rdy(lb_rd_rdy), .time_stamp_d(time_stamp_d),
    .slv_cs(slv_cs), .slv_wr(slv_wr), .slv_rd(slv_rd), .slv_addr(slv_addr),
    .slv_wr_d(slv_wr_d), .slv_rd_d(slv_rd_d), .slv_rd_rdy(slv_rd_rdy),
    .err_irq(err_irq)
  );

  initial clk_lb = 1'b0;
  always #5 clk_lb = ~clk_lb;

  always @(posedge clk_lb) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, observed, expected);
    end
  endtask

  // Drives a one-cycle master strobe starting from a negedge; returns at the next negedge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] data);
    lb_wr   = wr;
    lb_rd   = rd;
    lb_addr = addr;
    lb_wr_d = data;
    @(negedge clk_lb);
    lb_wr   = 1'b0;
    lb_rd   = 1'b0;
    lb_addr = '0;
    lb_wr_d = '0;
  endtask

  task automatic expectRead(input logic [31:0] addr, input logic [31:0] data, input int latency);
    exp_t e;
    e.data = data;
    e.cyc  = cyc + latency;
    exp_q.push_back(e);
    applyStimulus(1'b0, 1'b1, addr, 32'd0);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk_lb);
      n++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk_lb);
  endtask

  task automatic checkStatus(input logic [31:0] expected);
    expectRead(32'h0C, expected, 2);
    waitDrain();
  endtask

  task automatic slaveRespond(input logic [1:0] rdy, input logic [63:0] data);
    slv_rd_d   = data;
    slv_rd_rdy = rdy;
    @(negedge clk_lb);
    slv_rd_rdy = '0;
    slv_rd_d   = '0;
  endtask

  // Response monitor: every lb_rd_rdy must match the oldest queued expectation.
  always @(negedge clk_lb) begin
    if (lb_rd_rdy) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_rdy", 32'(lb_rd_rdy), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("rd_data", lb_rd_d, e.data);
        checkOutput("rd_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    exp_t e;
    reset        = 1'b0;
    lb_wr        = 1'b0;
    lb_rd        = 1'b0;
    lb_addr      = '0;
    lb_wr_d      = '0;
    time_stamp_d = 32'h5F000000;
    slv_rd_d     = '0;
    slv_rd_rdy   = '0;
    repeat (3) @(negedge clk_lb);
    checkOutput("rst_rd_d", lb_rd_d, 32'd0);
    checkOutput("rst_wr_d", slv_wr_d, 32'd0);
    checkOutput("rst_ctrl", 32'({lb_rd_rdy, slv_cs, slv_wr, slv_rd, slv_addr, err_irq}), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk_lb);

    $display("[TB] local register reads");
    expectRead(32'h00, 32'h11223344, 2);
    expectRead(32'h04, 32'h00000204, 2);
    expectRead(32'h08, 32'h5F000000, 2);
    expectRead(32'h0E, 32'h00000000, 2);
    waitDrain();
    checkStatus(32'h0);

    $display("[TB] slave write and read");
    applyStimulus(1'b1, 1'b0, 32'h14, 32'hA5A5A5A5);
    checkOutput("wr_cs", 32'(slv_cs), 32'h1);
    checkOutput("wr_addr", 32'(slv_addr), 32'h4);
    checkOutput("wr_strobes", 32'({slv_wr, slv_rd}), 32'h2);
    checkOutput("wr_data", slv_wr_d, 32'hA5A5A5A5);
    @(negedge clk_lb);
    checkOutput("wr_cs_drop", 32'({slv_cs, slv_wr}), 32'h0);
    c = cyc;
    e.data = 32'h12345678;
    e.cyc  = c + 5;
    exp_q.push_back(e);
    applyStimulus(1'b0, 1'b1, 32'h24, 32'd0);
    checkOutput("rd_cs", 32'({slv_cs, slv_rd, slv_wr}), 32'b1010);
    checkOutput("rd_addr", 32'(slv_addr), 32'h4);
    repeat (3) @(negedge clk_lb);
    slaveRespond(2'b10, {32'h12345678, 32'h0});
    waitDrain();
    checkStatus(32'h0);

    $display("[TB] slave read timeout");
    expectRead(32'h18, 32'hDEADBEEF, 2 + 8);
    waitDrain();
    checkStatus(32'h101);
    checkOutput("irq_set", 32'(err_irq), 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h0C, 32'h1);
    @(negedge clk_lb);
    checkOutput("irq_clr", 32'(err_irq), 32'h0);
    checkStatus(32'h100);

    $display("[TB] overrun and multiple rdy");
    c = cyc;
    e.data = 32'hCAFEF00D;
    e.cyc  = c + 3;
    exp_q.push_back(e);
    applyStimulus(1'b0, 1'b1, 32'h14, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h24, 32'd0);
    checkOutput("overrun_no_fwd", 32'(slv_rd), 32'h0);
    slaveRespond(2'b01, {32'h0, 32'hCAFEF00D});
    repeat (3) @(negedge clk_lb);
    waitDrain();
    checkStatus(32'h202);
    c = cyc;
    e.data = 32'h0BADF00D;
    e.cyc  = c + 2;
    exp_q.push_back(e);
    applyStimulus(1'b0, 1'b1, 32'h14, 32'd0);
    slaveRespond(2'b11, {32'h11111111, 32'h0BADF00D});
    waitDrain();
    checkStatus(32'h306);

    $display("[TB] unmapped accesses and count saturation");
    applyStimulus(1'b1, 1'b0, 32'h0C, 32'h8000000F);
    @(negedge clk_lb);
    checkStatus(32'h0);
    expectRead(32'h40, 32'hDEADBEEF, 2);
    waitDrain();
    checkStatus(32'h108);
    for (int i = 0; i < 299; i++) expectRead(32'h40, 32'hDEADBEEF, 2);
    waitDrain();
    checkStatus(32'hFF08);
    applyStimulus(1'b1, 1'b0, 32'h0C, 32'h80000000);
    @(negedge clk_lb);
    checkStatus(32'h0008);
    applyStimulus(1'b1, 1'b0, 32'h50, 32'h12121212);
    checkOutput("unm_wr_drop", 32'({slv_cs, slv_wr}), 32'h0);
    @(negedge clk_lb);
    checkStatus(32'h0108);

    $display("[TB] reset during WAIT");
    applyStimulus(1'b0, 1'b1, 32'h14, 32'd0);
    checkOutput("wait_rd", 32'(slv_rd), 32'h1);
    reset = 1'b0;
    @(negedge clk_lb);
    checkOutput("mid_rst_rd_d", lb_rd_d, 32'd0);
    checkOutput("mid_rst_wr_d", slv_wr_d, 32'd0);
    checkOutput("mid_rst_ctrl", 32'({lb_rd_rdy, slv_cs, slv_wr, slv_rd, slv_addr, err_irq}), 32'd0);
    reset = 1'b1;
    @(negedge clk_lb);
    slaveRespond(2'b01, {32'h0, 32'h77777777});
    repeat (12) @(negedge clk_lb);
    checkStatus(32'h104);
    checkOutput("stray_irq", 32'(err_irq), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lb_hub.md
Name: lb_hub

Overview:
- Parametrised local-bus hub for the SUMP2 capture designs; next generation of the fixed-decode top-level core glue.
- Sits between the host local-bus master (mesa/UART bridge) and NUM_SLV slave cores (gpio_core, sump2, future capture engines).
- Registers the bus, decodes NUM_SLV address windows plus one built-in register window, and forwards strobes.
- Tracks one outstanding slave read with timeout, error detection and a W1C status register; merges read data back to the master.

Parameters:
- NUM_SLV, 2, number of slave windows (1..14).
- WIN_BITS, 4, log2 of bytes per window.
- ADDR_BITS, 8, lb_addr bits decoded; upper bits ignored.
- TIMEOUT, 255, clk_lb cycles to wait for slave lb_rd_rdy (1..65535).
- HUB_ID, 32'H11223344, value of the ID register.

Ports:
- clk_lb  in  1  local-bus clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- lb_wr  in  1  master write strobe, single cycle.
- lb_rd  in  1  master read strobe, single cycle.
- lb_addr  in  32  master byte address.
- lb_wr_d  in  32  master write data.
- lb_rd_d  out  32  read data to master.
- lb_rd_rdy  out  1  read data valid, single-cycle pulse.
- time_stamp_d  in  32  synthesis timestamp.
- slv_cs  out  NUM_SLV  one-hot window select, registered.
- slv_wr  out  1  registered write strobe.
- slv_rd  out  1  registered read strobe.
- slv_addr  out  WIN_BITS  offset within window.
- slv_wr_d  out  32  registered write data.
- slv_rd_d  in  NUM_SLV*32  slave read data, slave i at [32i+31:32i].
- slv_rd_rdy  in  NUM_SLV  slave read-valid pulses.
- err_irq  out  1  OR of status bits [3:0].

Behaviour:
- Reset asserted: all outputs 0, FSM IDLE, status 0, timeout counter 0.
- Window decode: w = lb_addr[ADDR_BITS-1:WIN_BITS]. w=0 is the local window. w=1..NUM_SLV selects slave w-1. Any other w is unmapped.
- Stage p1, cycle +1: slv_cs, slv_wr, slv_rd, slv_addr and slv_wr_d are driven from the registered inputs.
  - slv_wr and slv_rd pulse only when a slave window is hit.
  - slv_cs holds for exactly that cycle.
- Local registers, offsets within window 0:
  - 0x0: HUB_ID.
  - 0x4: {16'd0, NUM_SLV[7:0], WIN_BITS[7:0]}.
  - 0x8: time_stamp_d.
  - 0xC: STATUS.
  - Other offsets read 0.
- Local and unmapped reads respond at cycle +2.
- Unmapped read: returns 32'HDEADBEEF and sets STATUS[3].
- Unmapped write: dropped and sets STATUS[3].
- STATUS layout:
  - [0] read timeout.
  - [1] read overrun.
  - [2] stray/multiple rdy.
  - [3] unmapped access.
  - [15:8] error count, saturating at 255, incremented once per cycle in which any of [3:0] is newly set.
  - [31:16] read as 0.
- STATUS write at 0xC: writing 1 clears the matching bit of [3:0]. lb_wr_d[31]=1 clears the count. A set and a clear of the same bit in one cycle resolves to set.
- Read FSM:
  - IDLE: slave read at p1 -> WAIT, counter loaded with TIMEOUT.
  - WAIT, slv_rd_rdy has any bit set: lb_rd_d = data of the lowest set index, registered, so lb_rd_rdy pulses one cycle after the slave rdy; go to IDLE. More than one bit set also sets STATUS[2].
  - WAIT, counter reaches 0 with no rdy: lb_rd_d = 32'HDEADBEEF, lb_rd_rdy pulses, STATUS[0] set, go to IDLE.
  - WAIT, new lb_rd from master: the read is not forwarded, STATUS[1] set, no response.
  - WAIT, lb_wr from master: forwarded normally.
  - slv_rd_rdy arriving in IDLE: ignored, STATUS[2] set.
- Rdy on the same cycle the counter hits 0: the slave data wins and no timeout is flagged.
- Simultaneous lb_wr and lb_rd: both forwarded.
- Reset during WAIT: FSM returns to IDLE, no lb_rd_rdy is emitted, and a late slave rdy after reset release sets STATUS[2].
- lb_rd_rdy is never asserted for two consecutive reads closer than the latencies above, and is never asserted without a prior accepted read.

Test Plan:
- Read 0x00, 0x04, 0x08 with NUM_SLV=2, WIN_BITS=4, time_stamp_d=32'H5F000000 -> lb_rd_rdy at +2 with 11223344, 00000204, 5F000000.
- Write 0x14 with data A5A5A5A5 -> at +1 slv_cs=2'b01, slv_addr=4, slv_wr=1, slv_wr_d=A5A5A5A5. Read 0x24 with slave 1 returning 12345678 three cycles later -> lb_rd_d=12345678, one cycle after the slave rdy.
- Read 0x18 with slave silent and TIMEOUT=8 -> DEADBEEF returned when the counter reaches 0. STATUS reads 0x00000101 and err_irq=1. Write 0xC with data 1 -> STATUS reads 0x00000100 and err_irq=0.
- During WAIT issue a second read; slave then answers 0xCAFEF00D -> single lb_rd_rdy with CAFEF00D and STATUS[1]=1. Pulse slv_rd_rdy=2'b11 during a later WAIT -> slave 0 data returned and STATUS[2]=1.
- Read 0x40 (unmapped) -> DEADBEEF at +2 and STATUS[3]=1. Repeat 300 error events -> count saturates at 0xFF. Write 0xC with 0x80000000 -> count reads 0.
- Assert reset mid-WAIT, release, then the slave pulses rdy -> no lb_rd_rdy, all outputs 0 during reset, STATUS=0x00000104 afterwards.
